// File: rtl/timer_prescaler_if.sv
// Control and tick bundle between timer_prescaler and its two timer channels.
// The controller side drives selects, prescaler clear and external pins.
interface timer_prescaler_if;
   logic [2:0] cs0;
   logic [2:0] cs1;
   logic       psr_reset;
   logic       t0_pin;
   logic       t1_pin;
   logic       tick0;
   logic       tick1;
   logic [9:0] prescale_count;

   modport slave (
      input  cs0,
      input  cs1,
      input  psr_reset,
      input  t0_pin,
      input  t1_pin,
      output tick0,
      output tick1,
      output prescale_count
   );

   modport master (
      output cs0,
      output cs1,
      output psr_reset,
      output t0_pin,
      output t1_pin,
      input  tick0,
      input  tick1,
      input  prescale_count
   );
endinterface

// File: rtl/timer_prescaler.sv
// Shared 10-bit prescaler producing registered count enables for timer0/timer1.
// Define TIMER_PRESCALER_EXT_CLK_EN to enable external-pin clocking (selects 6/7).
module timer_prescaler (
   input  logic             sysClock,
   input  logic             rst,
   timer_prescaler_if.slave bus
);

   typedef enum logic [2:0] {
      SelNone    = 3'd0,
      SelClk     = 3'd1,
      SelDiv8    = 3'd2,
      SelDiv64   = 3'd3,
      SelDiv256  = 3'd4,
      SelDiv1024 = 3'd5,
      SelExtFall = 3'd6,
      SelExtRise = 3'd7
   } sel_e;

   logic [9:0] count_q, count_d;
   logic [1:0] tick_q, tick_d;
   logic [3:0] taps;
   logic [1:0] ext_rise;
   logic [1:0] ext_fall;

   // A tap fires on the last count of each period; a clearing cycle never fires.
   always_comb begin
      count_d = bus.psr_reset ? 10'd0 : count_q + 10'd1;
      taps[0] = (&count_q[2:0]) & ~bus.psr_reset;
      taps[1] = (&count_q[5:0]) & ~bus.psr_reset;
      taps[2] = (&count_q[7:0]) & ~bus.psr_reset;
      taps[3] = (&count_q[9:0]) & ~bus.psr_reset;
   end

   function automatic logic sel_tick(input sel_e sel, input logic [3:0] tap,
                                     input logic rise, input logic fall);
      logic t;
      t = 1'b0;
      case (sel)
         SelNone:    t = 1'b0;
         SelClk:     t = 1'b1;
         SelDiv8:    t = tap[0];
         SelDiv64:   t = tap[1];
         SelDiv256:  t = tap[2];
         SelDiv1024: t = tap[3];
         SelExtFall: t = fall;
         SelExtRise: t = rise;
         default:    t = 1'b0;
      endcase
      return t;
   endfunction

`ifdef TIMER_PRESCALER_EXT_CLK_EN
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] prev_q, prev_d;
   logic [1:0] rise_q, rise_d;
   logic [1:0] fall_q, fall_d;
   logic [1:0] prime_q, prime_d;
   logic       primed;

   // Edges are detected every cycle whatever the select, so switching to 6/7
   // never sees stale history; the prime counter hides reset-time pin levels.
   always_comb begin
      primed  = (prime_q == 2'd3);
      prime_d = primed ? prime_q : prime_q + 2'd1;
      sync1_d = {bus.t1_pin, bus.t0_pin};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      rise_d  = primed ? (sync2_q & ~prev_q) : 2'b00;
      fall_d  = primed ? (~sync2_q & prev_q) : 2'b00;
   end

   always_ff @(posedge sysClock) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         prev_q  <= 2'b00;
         rise_q  <= 2'b00;
         fall_q  <= 2'b00;
         prime_q <= 2'd0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         prime_q <= prime_d;
      end
   end

   assign ext_rise = rise_q;
   assign ext_fall = fall_q;
`else
   logic unused_pins;

   assign unused_pins = bus.t0_pin ^ bus.t1_pin;
   assign ext_rise    = 2'b00;
   assign ext_fall    = 2'b00;
`endif

   always_comb begin
      tick_d[0] = sel_tick(sel_e'(bus.cs0), taps, ext_rise[0], ext_fall[0]);
      tick_d[1] = sel_tick(sel_e'(bus.cs1), taps, ext_rise[1], ext_fall[1]);
   end

   always_ff @(posedge sysClock) begin
      if (rst) begin
         count_q <= 10'd0;
         tick_q  <= 2'b00;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.tick0          = tick_q[0];
   assign bus.tick1          = tick_q[1];
   assign bus.prescale_count = count_q;

endmodule
